// File: rtl/ntsc_sync_sep.sv
// NTSC composite sync separator: slices sync, classifies pulse widths and
// flywheel-locks horizontal/vertical counters to the incoming video.
module ntsc_sync_sep #(
    parameter int C_DAT_W     = 9,
    parameter int C_H_TOTAL   = 910,
    parameter int C_V_TOTAL   = 525,
    parameter int C_HSYNC_MIN = 48,
    parameter int C_VSYNC_MIN = 256,
    parameter int C_H_ALIGN   = 70,
    parameter int C_H_TOL     = 8,
    parameter int C_V_ALIGN   = 3,
    parameter int C_LOCK_N    = 8,
    parameter int C_UNLOCK_N  = 8
) (
    input  logic               CK_i,
    input  logic               SR_i,
    input  logic               CK_EE_i,
    input  logic [C_DAT_W-1:0] VIDEOs_i,
    input  logic [C_DAT_W-1:0] SLICE_LVs_i,
    output logic               XHD_o,
    output logic               XVD_o,
    output logic [9:0]         HCTRs_o,
    output logic [9:0]         VCTRs_o,
    output logic               FIELD_o,
    output logic               LOCK_o,
    output logic               HSYNC_o
);

    localparam int GW = $clog2(C_LOCK_N + 1);
    localparam int MW = $clog2(C_UNLOCK_N + 1);

    localparam logic [9:0] H_LAST  = 10'(C_H_TOTAL - 1);
    localparam logic [9:0] H_HALF  = 10'(C_H_TOTAL / 2);
    localparam logic [9:0] V_LAST  = 10'(C_V_TOTAL - 1);
    localparam logic [9:0] H_LOAD  = 10'(C_H_ALIGN);
    localparam logic [9:0] V_LOAD  = 10'(C_V_ALIGN);
    localparam logic [9:0] WIN_LO  = 10'(C_H_ALIGN - 1 - C_H_TOL);
    localparam logic [9:0] WIN_HI  = 10'(C_H_ALIGN - 1 + C_H_TOL);
    localparam logic [9:0] MISS_AT = 10'(C_H_ALIGN + C_H_TOL);
    localparam logic [9:0] HS_MIN  = 10'(C_HSYNC_MIN);
    localparam logic [9:0] BR_MIN  = 10'(C_VSYNC_MIN);
    localparam logic [GW-1:0] GOOD_LAST = GW'(C_LOCK_N - 1);
    localparam logic [MW-1:0] MISS_LAST = MW'(C_UNLOCK_N - 1);

    typedef enum logic {
        S_UNLOCK,
        S_LOCK
    } state_t;

    state_t        state_q, state_d;
    logic          raw_q;
    logic          sync_q;
    logic [1:0]    run_q;
    logic [9:0]    width_q;
    logic [9:0]    hctr_q, hctr_d;
    logic [9:0]    vctr_q, vctr_d;
    logic [GW-1:0] good_q, good_d;
    logic [MW-1:0] miss_q, miss_d;
    logic          goth_q, goth_d;
    logic [1:0]    broad_q, broad_d;
    logic          field_q, field_d;
    logic          xhd_q, xvd_q, hsync_q;

    logic flip, fall, rise;
    logic is_hs, is_br, in_win;
    logic wrap, reload, vsync;

    // sync_q is the filtered slicer: 1 while the video sits below threshold
    assign flip   = (raw_q != sync_q) && (run_q == 2'd2);
    assign fall   = flip && raw_q;
    assign rise   = flip && !raw_q;
    assign is_hs  = rise && (width_q >= HS_MIN) && (width_q < BR_MIN);
    assign is_br  = rise && (width_q >= BR_MIN);
    assign in_win = (hctr_q >= WIN_LO) && (hctr_q <= WIN_HI);
    assign wrap   = (hctr_q == H_LAST);
    assign vsync  = is_br && (broad_q == 2'd2);

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        miss_d  = miss_q;
        goth_d  = goth_q;
        reload  = 1'b0;
        unique case (state_q)
            S_UNLOCK: begin
                if (is_hs) begin
                    reload = 1'b1;
                    if (!in_win) begin
                        good_d = '0;
                    end else if (good_q == GOOD_LAST) begin
                        state_d = S_LOCK;
                        good_d  = '0;
                        miss_d  = '0;
                    end else begin
                        good_d = good_q + GW'(1);
                    end
                end
            end
            S_LOCK: begin
                if (is_hs && in_win) begin
                    reload = 1'b1;
                    goth_d = 1'b1;
                end
                // one flywheel checkpoint per line, just past the window
                if (hctr_q == MISS_AT) begin
                    goth_d = 1'b0;
                    if (goth_q) begin
                        miss_d = '0;
                    end else if (miss_q == MISS_LAST) begin
                        state_d = S_UNLOCK;
                        miss_d  = '0;
                    end else begin
                        miss_d = miss_q + MW'(1);
                    end
                end
            end
            default: state_d = S_UNLOCK;
        endcase
    end

    always_comb begin
        hctr_d  = hctr_q + 10'd1;
        vctr_d  = vctr_q;
        broad_d = broad_q;
        field_d = field_q;
        if (reload) begin
            hctr_d = H_LOAD;
        end else if (wrap) begin
            hctr_d = '0;
            vctr_d = (vctr_q == V_LAST) ? 10'd0 : vctr_q + 10'd1;
        end
        if (is_hs) begin
            broad_d = '0;
        end else if (is_br && broad_q != 2'd3) begin
            broad_d = broad_q + 2'd1;
        end
        if (vsync) begin
            vctr_d  = V_LOAD;
            field_d = (hctr_q >= H_HALF);
        end
    end

    always_ff @(posedge CK_i) begin
        if (SR_i) begin
            state_q <= S_UNLOCK;
            raw_q   <= 1'b0;
            sync_q  <= 1'b0;
            run_q   <= '0;
            width_q <= '0;
            hctr_q  <= '0;
            vctr_q  <= '0;
            good_q  <= '0;
            miss_q  <= '0;
            goth_q  <= 1'b0;
            broad_q <= '0;
            field_q <= 1'b0;
            xhd_q   <= 1'b1;
            xvd_q   <= 1'b1;
            hsync_q <= 1'b0;
        end else if (CK_EE_i) begin
            raw_q <= (VIDEOs_i < SLICE_LVs_i);
            if (raw_q == sync_q) begin
                run_q <= '0;
            end else if (flip) begin
                sync_q <= raw_q;
                run_q  <= '0;
            end else begin
                run_q <= run_q + 2'd1;
            end
            if (fall) begin
                width_q <= '0;
            end else if (sync_q && width_q != 10'h3ff) begin
                width_q <= width_q + 10'd1;
            end
            state_q <= state_d;
            hctr_q  <= hctr_d;
            vctr_q  <= vctr_d;
            good_q  <= good_d;
            miss_q  <= miss_d;
            goth_q  <= goth_d;
            broad_q <= broad_d;
            field_q <= field_d;
            xhd_q   <= !wrap;
            xvd_q   <= (vctr_q != 10'd0);
            hsync_q <= is_hs;
        end
    end

    assign XHD_o   = xhd_q;
    assign XVD_o   = xvd_q;
    assign HCTRs_o = hctr_q;
    assign VCTRs_o = vctr_q;
    assign FIELD_o = field_q;
    assign LOCK_o  = (state_q == S_LOCK);
    assign HSYNC_o = hsync_q;

endmodule

// File: tb/tb_ntsc_sync_sep.sv
// Directed bench for ntsc_sync_sep: locks to synthetic 910-sample lines,
// then exercises glitches, flywheel, vsync/field and coincident events.
module tb_ntsc_sync_sep;

    localparam logic [8:0] BLANK = 9'd128;
    localparam logic [8:0] SYNC  = 9'd0;

    logic       CK_i = 1'b0;
    logic       SR_i = 1'b1;
    logic       CK_EE_i = 1'b1;
    logic [8:0] VIDEOs_i = SYNC;
    logic [8:0] SLICE_LVs_i = 9'd64;
    logic       XHD_o, XVD_o, FIELD_o, LOCK_o, HSYNC_o;
    logic [9:0] HCTRs_o, VCTRs_o;

    int checks = 0;
    int failures = 0;

    always #5 CK_i = ~CK_i;

    // short frame so the vertical wrap is reachable in a short run
    ntsc_sync_sep #(.C_V_TOTAL(12)) dut (
        .CK_i        (CK_i),
        .SR_i        (SR_i),
        .CK_EE_i     (CK_EE_i),
        .VIDEOs_i    (VIDEOs_i),
        .SLICE_LVs_i (SLICE_LVs_i),
        .XHD_o       (XHD_o),
        .XVD_o       (XVD_o),
        .HCTRs_o     (HCTRs_o),
        .VCTRs_o     (VCTRs_o),
        .FIELD_o     (FIELD_o),
        .LOCK_o      (LOCK_o),
        .HSYNC_o     (HSYNC_o)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run(input int n, input logic [8:0] v);
        for (int i = 0; i < n; i++) begin
            VIDEOs_i = v;
            @(posedge CK_i);
            #1;
        end
    endtask

    // 67-sample sync at sample 0; classification lands on sample 70
    task automatic line_chk(input string tag, input int x, input int lk);
        run(1, SYNC);
        chk({tag, ".xhd"}, int'(XHD_o), x);
        run(66, SYNC);
        run(4, BLANK);
        chk({tag, ".hsync"}, int'(HSYNC_o), 1);
        chk({tag, ".hctr"}, int'(HCTRs_o), 70);
        chk({tag, ".lock"}, int'(LOCK_o), lk);
        run(839, BLANK);
    endtask

    task automatic eq_line();
        run(33, SYNC);
        run(422, BLANK);
        run(33, SYNC);
        run(422, BLANK);
    endtask

    task automatic broad_line();
        run(388, SYNC);
        run(67, BLANK);
        run(388, SYNC);
        run(67, BLANK);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // reset mid-pulse, across both enable phases
        @(posedge CK_i);
        #1;
        CK_EE_i = 1'b0;
        @(posedge CK_i);
        #1;
        SR_i = 1'b0;
        chk("rst.xhd", int'(XHD_o), 1);
        chk("rst.xvd", int'(XVD_o), 1);
        chk("rst.hctr", int'(HCTRs_o), 0);
        chk("rst.vctr", int'(VCTRs_o), 0);
        chk("rst.field", int'(FIELD_o), 0);
        chk("rst.lock", int'(LOCK_o), 0);
        chk("rst.hsync", int'(HSYNC_o), 0);
        run(1, BLANK);
        chk("hold.hctr", int'(HCTRs_o), 0);
        CK_EE_i = 1'b1;
        run(1, BLANK);
        chk("en1.hctr", int'(HCTRs_o), 1);
        chk("en1.xvd", int'(XVD_o), 0);
        chk("en1.xhd", int'(XHD_o), 1);

        for (int k = 1; k <= 8; k++)
            line_chk($sformatf("acq%0d", k), (k == 1) ? 1 : 0, (k == 8) ? 1 : 0);
        line_chk("l9", 0, 1);

        // 2-sample bump inside the sync must not split it
        run(30, SYNC);
        run(2, BLANK);
        run(35, SYNC);
        run(4, BLANK);
        chk("glitch.hsync", int'(HSYNC_o), 1);
        chk("glitch.hctr", int'(HCTRs_o), 70);
        run(839, BLANK);

        run(33, SYNC);
        run(4, BLANK);
        chk("eq.hsync", int'(HSYNC_o), 0);
        run(873, BLANK);
        chk("eq.hctr", int'(HCTRs_o), 909);
        chk("eq.lock", int'(LOCK_o), 1);

        line_chk("l12", 0, 1);
        run(7 * 910, BLANK);
        line_chk("fly7", 0, 1);

        // 20-sample phase jump while locked
        run(20, BLANK);
        run(67, SYNC);
        run(4, BLANK);
        chk("jump.hsync", int'(HSYNC_o), 1);
        chk("jump.hctr", int'(HCTRs_o), 90);
        chk("jump.lock", int'(LOCK_o), 1);
        run(819, BLANK);

        line_chk("l22", 0, 1);
        run(7 * 910, BLANK);
        run(79, BLANK);
        chk("fly8.before", int'(LOCK_o), 1);
        run(1, BLANK);
        chk("fly8.after", int'(LOCK_o), 0);
        run(830, BLANK);

        // vsync at line start: third broad rises at sample 391
        eq_line();
        eq_line();
        eq_line();
        broad_line();
        run(388, SYNC);
        run(4, BLANK);
        chk("vs0.vctr", int'(VCTRs_o), 3);
        chk("vs0.field", int'(FIELD_o), 0);
        run(63, BLANK);
        run(388, SYNC);
        run(67, BLANK);
        broad_line();

        // hsync trailing edge coincides with HCTRs==909
        run(840, BLANK);
        run(67, SYNC);
        run(3, BLANK);
        run(1, BLANK);
        chk("coh.hctr", int'(HCTRs_o), 70);
        chk("coh.vctr", int'(VCTRs_o), 5);
        chk("coh.hsync", int'(HSYNC_o), 1);
        run(839, BLANK);

        // vsync coincides with the natural wrap
        broad_line();
        run(519, BLANK);
        run(388, SYNC);
        run(3, BLANK);
        run(1, BLANK);
        chk("cov.vctr", int'(VCTRs_o), 3);
        chk("cov.field", int'(FIELD_o), 1);
        chk("cov.hctr", int'(HCTRs_o), 0);
        run(909, BLANK);

        for (int k = 1; k <= 8; k++)
            line_chk($sformatf("n%0d", k), 0, (k == 8) ? 1 : 0);
        chk("pre.vctr", int'(VCTRs_o), 11);
        chk("pre.xvd", int'(XVD_o), 1);
        line_chk("n9", 0, 1);
        chk("v0.vctr", int'(VCTRs_o), 0);
        chk("v0.xvd", int'(XVD_o), 0);
        run(1, SYNC);
        chk("v1.vctr", int'(VCTRs_o), 1);
        chk("v1.xvd", int'(XVD_o), 0);
        run(1, SYNC);
        chk("v1.xvd_hi", int'(XVD_o), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
